// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/branch/memory-wait controller for an in-order core.
// Also keeps saturating counters of hazard cycles and stall cycles.
module pipeline_ctrl #(
    parameter int FWD_EN      = 0,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    input  logic             two_src,
    input  logic [3:0]       ex_dest,
    input  logic [3:0]       mem_dest,
    input  logic             ex_wb_en,
    input  logic             mem_wb_en,
    input  logic             ex_mem_r_en,
    input  logic             ex_branch_taken,
    input  logic [31:0]      ex_branch_addr,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             clr_cnt,
    output logic             freeze,
    output logic             pipe_stall,
    output logic             flush,
    output logic             branch_taken,
    output logic [31:0]      branch_address,
    output logic             mem_err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] hazard_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t            cur_state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              raw;
    logic              hazard;
    logic              mem_busy;
    logic              wait_expired;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // With forwarding only a load in EX can't supply its result in time.
    always_comb begin
        raw = 1'b0;
        if (FWD_EN != 0)
            raw = ex_mem_r_en & ex_wb_en &
                  ((src1 == ex_dest) | (two_src & (src2 == ex_dest)));
        else
            raw = ((src1 == ex_dest) & ex_wb_en) | ((src1 == mem_dest) & mem_wb_en) |
                  (two_src & (((src2 == ex_dest) & ex_wb_en) |
                              ((src2 == mem_dest) & mem_wb_en)));
    end

    assign hazard       = id_valid & raw & ~ex_branch_taken;
    assign mem_busy     = mem_req & ~mem_ready;
    assign wait_expired = (wait_cnt == WAIT_LAST) & ~mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cur_state <= RUN;
        else
            cur_state <= next_state;
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            RUN:      if (mem_busy) next_state = MEM_WAIT;
            MEM_WAIT: begin
                if (mem_ready)
                    next_state = RUN;
                else if (wait_expired)
                    next_state = ERR;
            end
            ERR:      next_state = ERR;
            default:  next_state = RUN;
        endcase
    end

    always_comb begin
        pipe_stall = 1'b0;
        mem_err    = 1'b0;
        case (cur_state)
            RUN:      pipe_stall = mem_busy;
            MEM_WAIT: pipe_stall = ~mem_ready;
            ERR: begin
                pipe_stall = 1'b1;
                mem_err    = 1'b1;
            end
            default: ;
        endcase
    end

    // Held at zero in RUN so every MEM_WAIT visit starts counting from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (cur_state != MEM_WAIT)
            wait_cnt <= '0;
        else if (wait_cnt != WAIT_LAST)
            wait_cnt <= wait_cnt + WAIT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hazard_cnt <= '0;
            stall_cnt  <= '0;
        end else if (clr_cnt) begin
            hazard_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (hazard & ~pipe_stall)
                hazard_cnt <= sat_inc(hazard_cnt);
            if (pipe_stall)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

    // A branch seen during a stall stays in EX and redirects once the stall clears.
    assign freeze         = hazard | pipe_stall;
    assign flush          = ex_branch_taken & ~pipe_stall;
    assign branch_taken   = flush;
    assign branch_address = branch_taken ? ex_branch_addr : 32'd0;
    assign state          = cur_state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: one instance without forwarding (defaults) and one
// with forwarding, narrow counters and a short timeout, driven by shared inputs.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, id_valid, two_src, ex_wb_en, mem_wb_en, ex_mem_r_en;
    logic        ex_branch_taken, mem_req, mem_ready, clr_cnt;
    logic [3:0]  src1, src2, ex_dest, mem_dest;
    logic [31:0] ex_branch_addr;

    logic        freeze_o[2], stall_o[2], flush_o[2], bt_o[2], err_o[2];
    logic [31:0] baddr_o[2];
    logic [1:0]  state_o[2];
    logic [15:0] hc0, sc0;
    logic [3:0]  hc1, sc1;

    pipeline_ctrl #(.FWD_EN(0), .CNT_W(16), .MEM_TIMEOUT(15)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
        .two_src(two_src), .ex_dest(ex_dest), .mem_dest(mem_dest),
        .ex_wb_en(ex_wb_en), .mem_wb_en(mem_wb_en), .ex_mem_r_en(ex_mem_r_en),
        .ex_branch_taken(ex_branch_taken), .ex_branch_addr(ex_branch_addr),
        .mem_req(mem_req), .mem_ready(mem_ready), .clr_cnt(clr_cnt),
        .freeze(freeze_o[0]), .pipe_stall(stall_o[0]), .flush(flush_o[0]),
        .branch_taken(bt_o[0]), .branch_address(baddr_o[0]), .mem_err(err_o[0]),
        .state(state_o[0]), .hazard_cnt(hc0), .stall_cnt(sc0)
    );

    pipeline_ctrl #(.FWD_EN(1), .CNT_W(4), .MEM_TIMEOUT(5)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
        .two_src(two_src), .ex_dest(ex_dest), .mem_dest(mem_dest),
        .ex_wb_en(ex_wb_en), .mem_wb_en(mem_wb_en), .ex_mem_r_en(ex_mem_r_en),
        .ex_branch_taken(ex_branch_taken), .ex_branch_addr(ex_branch_addr),
        .mem_req(mem_req), .mem_ready(mem_ready), .clr_cnt(clr_cnt),
        .freeze(freeze_o[1]), .pipe_stall(stall_o[1]), .flush(flush_o[1]),
        .branch_taken(bt_o[1]), .branch_address(baddr_o[1]), .mem_err(err_o[1]),
        .state(state_o[1]), .hazard_cnt(hc1), .stall_cnt(sc1)
    );

    // Reference model: mode 0=running, 1=waiting on memory, 2=timed out.
    int m_mode[2], m_waited[2], m_hc[2], m_sc[2];
    int m_to[2]  = '{15, 5};
    int m_max[2] = '{65535, 15};
    int m_fwd[2] = '{0, 1};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit f_match(input logic [3:0] s);
        return (s == ex_dest && ex_wb_en) || (s == mem_dest && mem_wb_en);
    endfunction

    function automatic bit f_hazard(input int i);
        bit r;
        if (m_fwd[i] != 0)
            r = ex_mem_r_en && ex_wb_en && (src1 == ex_dest || (two_src && src2 == ex_dest));
        else
            r = f_match(src1) || (two_src && f_match(src2));
        return id_valid && r && !ex_branch_taken;
    endfunction

    function automatic bit f_stall(input int i);
        if (m_mode[i] == 0) return mem_req && !mem_ready;
        if (m_mode[i] == 1) return !mem_ready;
        return 1'b1;
    endfunction

    function automatic void model_reset(input int i);
        m_mode[i] = 0; m_waited[i] = 0; m_hc[i] = 0; m_sc[i] = 0;
    endfunction

    task automatic model_next();
        bit st, hz;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                model_reset(i);
                continue;
            end
            st = f_stall(i);
            hz = f_hazard(i);
            if (clr_cnt) begin
                m_hc[i] = 0; m_sc[i] = 0;
            end else begin
                if (hz && !st && m_hc[i] < m_max[i]) m_hc[i]++;
                if (st && m_sc[i] < m_max[i]) m_sc[i]++;
            end
            if (m_mode[i] == 0) begin
                if (mem_req && !mem_ready) begin m_mode[i] = 1; m_waited[i] = 0; end
            end else if (m_mode[i] == 1) begin
                if (mem_ready) m_mode[i] = 0;
                else if (m_waited[i] == m_to[i] - 1) m_mode[i] = 2;
                else m_waited[i]++;
            end
        end
    endtask

    task automatic check_model();
        bit st, hz, br;
        for (int i = 0; i < 2; i++) begin
            st = f_stall(i);
            hz = f_hazard(i);
            br = ex_branch_taken && !st;
            chk($sformatf("pipe_stall[%0d]", i), 64'(stall_o[i]), 64'(st));
            chk($sformatf("freeze[%0d]", i), 64'(freeze_o[i]), 64'(hz || st));
            chk($sformatf("flush[%0d]", i), 64'(flush_o[i]), 64'(br));
            chk($sformatf("branch_taken[%0d]", i), 64'(bt_o[i]), 64'(br));
            chk($sformatf("branch_address[%0d]", i), 64'(baddr_o[i]),
                64'(br ? ex_branch_addr : 32'd0));
            chk($sformatf("mem_err[%0d]", i), 64'(err_o[i]), 64'(m_mode[i] == 2));
            chk($sformatf("state[%0d]", i), 64'(state_o[i]), 64'(m_mode[i]));
        end
        chk("hazard_cnt[0]", 64'(hc0), 64'(m_hc[0]));
        chk("stall_cnt[0]", 64'(sc0), 64'(m_sc[0]));
        chk("hazard_cnt[1]", 64'(hc1), 64'(m_hc[1]));
        chk("stall_cnt[1]", 64'(sc1), 64'(m_sc[1]));
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; src1 = 0; src2 = 0; two_src = 0; ex_dest = 0; mem_dest = 0;
        ex_wb_en = 0; mem_wb_en = 0; ex_mem_r_en = 0; ex_branch_taken = 0;
        ex_branch_addr = 0; mem_req = 0; mem_ready = 0; clr_cnt = 0;
    endtask

    task automatic clear_counters();
        clear_inputs();
        clr_cnt = 1;
        #1;
        check_model();
        tick();
        clr_cnt = 0;
    endtask

    typedef struct {
        int iv, s1, s2, two, exd, memd, exwb, memwb, ld, br, addr, req, rdy;
        int f0, f1, fl;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        //         iv s1 s2 2s exd md ewb mwb ld br addr   rq rd  f0 f1 fl
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0,  0, 0, 0};
        tbl[1]  = '{1, 3, 0, 0, 3, 0, 1, 0, 0, 0, 0,     0, 0,  1, 0, 0};
        tbl[2]  = '{1, 3, 0, 0, 3, 0, 1, 0, 1, 0, 0,     0, 0,  1, 1, 0};
        tbl[3]  = '{0, 3, 0, 0, 3, 0, 1, 0, 1, 0, 0,     0, 0,  0, 0, 0};
        tbl[4]  = '{1, 1, 5, 0, 2, 5, 1, 1, 0, 0, 0,     0, 0,  0, 0, 0};
        tbl[5]  = '{1, 1, 5, 1, 2, 5, 1, 1, 0, 0, 0,     0, 0,  1, 0, 0};
        tbl[6]  = '{1, 7, 0, 0, 0, 7, 0, 1, 0, 0, 0,     0, 0,  1, 0, 0};
        tbl[7]  = '{1, 7, 0, 0, 0, 7, 0, 0, 0, 0, 0,     0, 0,  0, 0, 0};
        tbl[8]  = '{1, 1, 9, 1, 9, 0, 1, 0, 1, 0, 0,     0, 0,  1, 1, 0};
        tbl[9]  = '{1, 3, 0, 0, 3, 0, 0, 0, 1, 0, 0,     0, 0,  0, 0, 0};
        tbl[10] = '{1, 3, 0, 0, 3, 0, 1, 0, 1, 1, 'h40,  0, 0,  0, 0, 1};
        tbl[11] = '{1, 3, 0, 0, 3, 0, 1, 0, 0, 0, 0,     1, 1,  1, 0, 0};
        tbl[12] = '{1, 6, 0, 0, 2, 6, 1, 1, 1, 0, 0,     0, 0,  1, 0, 0};

        // Reset state, checked before any clock edge.
        clear_inputs();
        rst = 1;
        model_reset(0);
        model_reset(1);
        #1;
        chk("reset_state0", 64'(state_o[0]), 64'd0);
        chk("reset_hc0", 64'(hc0), 64'd0);
        chk("reset_sc1", 64'(sc1), 64'd0);
        check_model();
        tick();
        tick();
        rst = 0;

        // Combinational vectors, all staying in RUN.
        for (int k = 0; k < 13; k++) begin
            id_valid = 1'(tbl[k].iv);   src1 = 4'(tbl[k].s1);      src2 = 4'(tbl[k].s2);
            two_src = 1'(tbl[k].two);   ex_dest = 4'(tbl[k].exd);  mem_dest = 4'(tbl[k].memd);
            ex_wb_en = 1'(tbl[k].exwb); mem_wb_en = 1'(tbl[k].memwb);
            ex_mem_r_en = 1'(tbl[k].ld); ex_branch_taken = 1'(tbl[k].br);
            ex_branch_addr = 32'(tbl[k].addr);
            mem_req = 1'(tbl[k].req);   mem_ready = 1'(tbl[k].rdy);
            #1;
            chk($sformatf("vec%0d_freeze0", k), 64'(freeze_o[0]), 64'(tbl[k].f0));
            chk($sformatf("vec%0d_freeze1", k), 64'(freeze_o[1]), 64'(tbl[k].f1));
            chk($sformatf("vec%0d_flush0", k), 64'(flush_o[0]), 64'(tbl[k].fl));
            chk($sformatf("vec%0d_flush1", k), 64'(flush_o[1]), 64'(tbl[k].fl));
            chk($sformatf("vec%0d_baddr0", k), 64'(baddr_o[0]),
                64'(tbl[k].fl != 0 ? tbl[k].addr : 0));
            chk($sformatf("vec%0d_stall0", k), 64'(stall_o[0]), 64'd0);
            check_model();
            tick();
        end

        // One RAW hazard cycle bumps hazard_cnt once (no forwarding only).
        clear_counters();
        id_valid = 1; src1 = 3; ex_dest = 3; ex_wb_en = 1;
        #1;
        chk("raw_freeze0", 64'(freeze_o[0]), 64'd1);
        chk("raw_flush0", 64'(flush_o[0]), 64'd0);
        tick();
        clear_inputs();
        #1;
        chk("raw_hazard_cnt0", 64'(hc0), 64'd1);
        chk("raw_hazard_cnt1", 64'(hc1), 64'd0);
        check_model();

        // Three-cycle memory wait.
        clear_counters();
        mem_req = 1; mem_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("mw_stall0_c%0d", k), 64'(stall_o[0]), 64'd1);
            check_model();
            tick();
        end
        mem_ready = 1;
        #1;
        chk("mw_ready_stall0", 64'(stall_o[0]), 64'd0);
        tick();
        clear_inputs();
        #1;
        chk("mw_state0", 64'(state_o[0]), 64'd0);
        chk("mw_stall_cnt0", 64'(sc0), 64'd3);
        chk("mw_stall_cnt1", 64'(sc1), 64'd3);
        check_model();

        // Branch deferred across a memory wait.
        mem_req = 1; mem_ready = 0; ex_branch_taken = 1; ex_branch_addr = 32'h80;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("brw_bt0_c%0d", k), 64'(bt_o[0]), 64'd0);
            chk($sformatf("brw_baddr0_c%0d", k), 64'(baddr_o[0]), 64'd0);
            check_model();
            tick();
        end
        mem_ready = 1;
        #1;
        chk("brw_bt0_release", 64'(bt_o[0]), 64'd1);
        chk("brw_baddr0_release", 64'(baddr_o[0]), 64'h80);
        check_model();
        tick();
        clear_inputs();
        #1;
        chk("brw_bt0_after", 64'(bt_o[0]), 64'd0);
        check_model();
        tick();

        // Memory timeout into ERR, counter saturation, clear priority, reset exit.
        clear_counters();
        mem_req = 1; mem_ready = 0;
        n = 0;
        while (state_o[0] !== 2'd2 && n < 40) begin
            #1;
            check_model();
            tick();
            n++;
        end
        chk("err_latency0", 64'(n), 64'd16);
        mem_req = 0;
        for (int k = 0; k < 20; k++) begin
            mem_ready = 1'(k & 1);
            #1;
            chk($sformatf("err_hold_stall0_c%0d", k), 64'(stall_o[0]), 64'd1);
            check_model();
            tick();
        end
        chk("err_mem_err0", 64'(err_o[0]), 64'd1);
        chk("sat_stall_cnt1", 64'(sc1), 64'd15);
        clr_cnt = 1;
        tick();
        clr_cnt = 0;
        chk("clr_prio_sc0", 64'(sc0), 64'd0);
        chk("clr_prio_sc1", 64'(sc1), 64'd0);
        tick();
        chk("post_clr_sc1", 64'(sc1), 64'd1);
        check_model();
        rst = 1;
        model_reset(0);
        model_reset(1);
        #1;
        chk("async_rst_state0", 64'(state_o[0]), 64'd0);
        chk("async_rst_mem_err0", 64'(err_o[0]), 64'd0);
        chk("async_rst_stall0", 64'(stall_o[0]), 64'd0);
        chk("async_rst_sc0", 64'(sc0), 64'd0);
        check_model();
        tick();
        rst = 0;

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            id_valid        = ($urandom_range(0, 3) != 0);
            src1            = 4'($urandom_range(0, 3));
            src2            = 4'($urandom_range(0, 3));
            two_src         = 1'($urandom_range(0, 1));
            ex_dest         = 4'($urandom_range(0, 3));
            mem_dest        = 4'($urandom_range(0, 3));
            ex_wb_en        = 1'($urandom_range(0, 1));
            mem_wb_en       = 1'($urandom_range(0, 1));
            ex_mem_r_en     = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 6) == 0);
            ex_branch_addr  = $urandom;
            mem_req         = ($urandom_range(0, 2) == 0);
            mem_ready       = ($urandom_range(0, 4) > 1);
            clr_cnt         = ($urandom_range(0, 39) == 0);
            rst             = ($urandom_range(0, 59) == 0);
            if (rst) begin
                model_reset(0);
                model_reset(1);
            end
            #1;
            check_model();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter FWD_EN, default 0: 1 means forwarding exists, so only load-use hazards stall.
REQ-002 Parameter CNT_W, default 16: width of the performance counters.
REQ-003 Parameter MEM_TIMEOUT, default 15: maximum number of MEM_WAIT cycles before the error state.
REQ-004 clk  in  1  single clock; every flop is rising-edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 id_valid  in  1  ID stage holds a real instruction.
REQ-007 src1, src2  in  4 each  ID source register numbers.
REQ-008 two_src  in  1  src2 is read by the ID instruction.
REQ-009 ex_dest, mem_dest  in  4 each  destination registers in EX and MEM.
REQ-010 ex_wb_en, mem_wb_en  in  1 each  write-back enables in EX and MEM.
REQ-011 ex_mem_r_en  in  1  the EX instruction is a load.
REQ-012 ex_branch_taken  in  1  EX resolved a taken branch.
REQ-013 ex_branch_addr  in  32  target of that branch.
REQ-014 mem_req  in  1  MEM stage is accessing data memory.
REQ-015 mem_ready  in  1  data memory completes the access this cycle.
REQ-016 clr_cnt  in  1  synchronous clear of the counters.
REQ-017 freeze  out  1  hold PC, the IF/ID register and ID.
REQ-018 pipe_stall  out  1  hold every pipeline register.
REQ-019 flush  out  1  kill IF/ID and ID/EX contents.
REQ-020 branch_taken  out  1  load branch_address into the PC.
REQ-021 branch_address  out  32  PC redirect target.
REQ-022 mem_err  out  1  sticky memory-timeout flag.
REQ-023 state  out  2  FSM state: RUN=0, MEM_WAIT=1, ERR=2.
REQ-024 hazard_cnt, stall_cnt  out  CNT_W each  performance counters.

Function
REQ-025 Define match(s) = (s==ex_dest & ex_wb_en) | (s==mem_dest & mem_wb_en).
REQ-026 For FWD_EN=0, define raw = match(src1) | (two_src & match(src2)).
REQ-027 For FWD_EN=1, define raw = ex_mem_r_en & ex_wb_en & (src1==ex_dest | (two_src & src2==ex_dest)).
REQ-028 hazard = id_valid & raw & !ex_branch_taken; it is combinational with zero latency.
REQ-029 pipe_stall = (state==RUN & mem_req & !mem_ready) | (state==MEM_WAIT & !mem_ready) | state==ERR; it is combinational.
REQ-030 freeze = hazard | pipe_stall.
REQ-031 flush and branch_taken = ex_branch_taken & !pipe_stall; this is a one-cycle pulse per taken branch while the pipeline is not stalled.
REQ-032 branch_address = ex_branch_addr whenever branch_taken=1, and 0 otherwise.
REQ-033 A branch in EX during a stall is deferred, not lost: EX is held, so branch_taken asserts in the first cycle pipe_stall=0.
REQ-034 Transition RUN->MEM_WAIT when mem_req & !mem_ready; otherwise the FSM stays in RUN.
REQ-035 Transition MEM_WAIT->RUN when mem_ready.
REQ-036 Transition MEM_WAIT->ERR when wait_cnt==MEM_TIMEOUT-1 & !mem_ready.
REQ-037 ERR is absorbing until reset, and mem_err=1 while in ERR.
REQ-038 wait_cnt is an internal counter: cleared on entry to MEM_WAIT, incremented each MEM_WAIT cycle.
REQ-039 A single-cycle access (mem_req & mem_ready in RUN) causes no stall.
REQ-040 hazard_cnt increments in each cycle with hazard & !pipe_stall.
REQ-041 stall_cnt increments in each cycle with pipe_stall=1.
REQ-042 Both counters saturate at all-ones.
REQ-043 clr_cnt zeroes both counters at the next edge and takes priority over increment.

Reset
REQ-044 rst=1 immediately forces state=RUN, wait_cnt=0, mem_err=0, hazard_cnt=0 and stall_cnt=0, regardless of clk.
REQ-045 Reset asserted mid-MEM_WAIT or in ERR returns the FSM to RUN.
REQ-046 During reset, the combinational outputs follow their equations with state=RUN.

Verification
REQ-047 The bench SHALL cover: FWD_EN=0, id_valid=1, src1=3, ex_dest=3, ex_wb_en=1 -> freeze=1, flush=0 and hazard_cnt increments by 1.
REQ-048 The bench SHALL cover: FWD_EN=1, same stimulus with ex_mem_r_en=0 -> freeze=0; with ex_mem_r_en=1 -> freeze=1.
REQ-049 The bench SHALL cover: ex_branch_taken=1, ex_branch_addr=0x40, with a hazard present -> flush=1, branch_taken=1, branch_address=0x40 and freeze=0.
REQ-050 The bench SHALL cover: mem_req=1 and mem_ready=0 for 3 cycles, then 1 -> pipe_stall=1 for 3 cycles, state returns to 0, and stall_cnt=3.
REQ-051 The bench SHALL cover: mem_ready held at 0 with MEM_TIMEOUT=15 -> state=2 and mem_err=1, with pipe_stall held high until rst.
REQ-052 The bench SHALL cover: branch asserted during MEM_WAIT -> branch_taken=0 until the mem_ready cycle, then a single pulse.
